// File: rtl/peripheral_responder.sv
// peripheral_responder: memory-mapped timer (TH/TL/TCON), LED, seven-segment and systick registers
module peripheral_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        irq_out,
  output logic [7:0]  leds,
  output logic [11:0] digits,
  output logic [31:0] systick
);
  logic [31:0] th, tl, tl_nxt;
  logic [2:0]  tcon, tcon_nxt;
  logic [5:0]  hit;
  logic [4:0]  wr;
  logic        wrap;
  logic        unused_ok;
  for (genvar i = 0; i < 6; i++) begin : g_dec
    assign hit[i] = address[31:2] == BASE_ADDR[31:2] + 30'(i);
  end
  assign unused_ok = ^address[1:0];
  assign wr = {5{MemWrite}} & hit[4:0];
  assign wrap = tcon[0] & (&tl);
  // CPU writes override the timer's own count/reload and pending update
  assign tl_nxt = wr[1] ? write_data : !tcon[0] ? tl : wrap ? th : tl + 32'd1;
  assign tcon_nxt = wr[2] ? write_data[2:0] : {tcon[2] | (wrap & tcon[1]), tcon[1:0]};
  always_comb
    read_data = !MemRead ? 32'h0 :
                hit[0] ? th :
                hit[1] ? tl :
                hit[2] ? {29'h0, tcon} :
                hit[3] ? {24'h0, leds} :
                hit[4] ? {20'h0, digits} :
                hit[5] ? systick : 32'h0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      irq_out <= 1'b0;
      leds    <= '0;
      digits  <= '0;
      systick <= '0;
    end else begin
      if (wr[0]) th <= write_data;
      if (wr[3]) leds <= write_data[7:0];
      if (wr[4]) digits <= write_data[11:0];
      tl      <= tl_nxt;
      tcon    <= tcon_nxt;
      irq_out <= tcon_nxt[2] & tcon_nxt[1];
      systick <= systick + 32'd1;
    end
  end
endmodule

// File: tb/tb_peripheral_responder.sv
// tb_peripheral_responder: directed and random register traffic checked against a register-map model
module tb_peripheral_responder;
  localparam logic [31:0] BASE = 32'h40000000;
  localparam logic [31:0] A_TH = BASE, A_TL = BASE + 4, A_TCON = BASE + 8,
                          A_LED = BASE + 12, A_DIG = BASE + 16, A_ST = BASE + 20;
  logic clk = 0, reset = 0, MemRead = 0, MemWrite = 0;
  logic [31:0] address = 0, write_data = 0, read_data, systick;
  logic irq_out;
  logic [7:0] leds;
  logic [11:0] digits;
  int total = 0, bad = 0;
  logic [31:0] m_th, m_tl, m_led, m_dig, m_st, last_rd;
  logic [2:0] m_tcon;
  logic m_irq;

  peripheral_responder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .write_data(write_data), .read_data(read_data),
    .irq_out(irq_out), .leds(leds), .digits(digits), .systick(systick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int reg_of(input logic [31:0] a);
    for (int k = 0; k < 6; k++)
      if ((a & ~32'h3) == BASE + 32'(4 * k)) return k;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
    if (!rd) return 0;
    case (reg_of(a))
      0: return m_th;
      1: return m_tl;
      2: return {29'h0, m_tcon};
      3: return m_led & 32'hFF;
      4: return m_dig & 32'hFFF;
      5: return m_st;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_dig = 0; m_st = 0; m_irq = 0;
  endtask

  task automatic m_clock(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ntl = m_tl;
    logic [2:0] ntc = m_tcon;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFFFFFF) begin
        ntl = m_th;
        if (m_tcon[1]) ntc[2] = 1;
      end else ntl = m_tl + 1;
    end
    if (wr)
      case (reg_of(a))
        0: m_th = d;
        1: ntl = d;
        2: ntc = d[2:0];
        3: m_led = d & 32'hFF;
        4: m_dig = d & 32'hFFF;
        default: ;
      endcase
    m_tl = ntl;
    m_tcon = ntc;
    m_irq = ntc[2] & ntc[1];
    m_st = m_st + 1;
  endtask

  task automatic chk_outs();
    chk("leds", {24'h0, leds}, m_led);
    chk("digits", {20'h0, digits}, m_dig);
    chk("systick", systick, m_st);
    chk("irq", {31'h0, irq_out}, {31'h0, m_irq});
  endtask

  // one bus cycle: drive, check the combinational read, clock, check state
  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    MemRead = rd; MemWrite = wr; address = a; write_data = d;
    #1;
    last_rd = read_data;
    chk("read_data", read_data, m_read(rd, a));
    @(posedge clk);
    m_clock(wr, a, d);
    #1;
    chk_outs();
  endtask

  initial begin
    m_reset();
    #2;
    chk_outs();
    chk("rd_in_reset", read_data, 32'h0);
    #6 reset = 1;
    step(0, 0, 0, 0);
    chk("systick_first", systick, 32'd1);
    // timer wrap with reload and interrupt
    step(0, 1, A_TH, 32'hFFFFFFF0);
    step(0, 1, A_TL, 32'hFFFFFFFE);
    step(0, 1, A_TCON, 32'h3);
    step(1, 0, A_TL, 0);
    chk("tl_pre", last_rd, 32'hFFFFFFFE);
    step(1, 0, A_TL, 0);
    chk("tl_max", last_rd, 32'hFFFFFFFF);
    chk("irq_wrap", {31'h0, irq_out}, 32'h1);
    step(1, 0, A_TL, 0);
    chk("tl_reload", last_rd, 32'hFFFFFFF0);
    step(1, 0, A_TCON, 0);
    chk("tcon_pend", last_rd, 32'h7);
    // clear pending; a wrap coinciding with the TCON write must not re-set it
    step(0, 1, A_TCON, 32'h3);
    chk("irq_clear", {31'h0, irq_out}, 32'h0);
    step(0, 1, A_TL, 32'hFFFFFFFE);
    step(0, 0, 0, 0);
    step(0, 1, A_TCON, 32'h3);
    chk("irq_wr_prio", {31'h0, irq_out}, 32'h0);
    step(1, 0, A_TCON, 0);
    chk("tcon_wr_prio", last_rd, 32'h3);
    step(0, 1, A_TCON, 0);
    // LED / digit truncation
    step(0, 1, A_LED, 32'h12345678);
    step(0, 1, A_DIG, 32'hFFFFFABC);
    chk("leds_val", {24'h0, leds}, 32'h78);
    chk("digits_val", {20'h0, digits}, 32'hABC);
    step(1, 0, A_LED + 2, 0);
    chk("rd_led", last_rd, 32'h78);
    step(1, 0, A_DIG, 0);
    chk("rd_dig", last_rd, 32'hABC);
    // read-only and unmapped writes
    step(0, 1, A_ST, 32'hDEAD);
    step(0, 1, BASE + 32'h18, 32'hDEAD);
    step(1, 0, BASE + 32'h18, 0);
    chk("rd_unmapped", last_rd, 32'h0);
    step(1, 0, A_LED ^ 32'h1000_0000, 0);
    chk("rd_alias", last_rd, 32'h0);
    step(1, 1, A_LED, 32'hAA);
    chk("rd_wr_old", last_rd, 32'h78);
    step(0, 0, A_LED, 0);
    chk("rd_noread", last_rd, 32'h0);
    step(1, 0, A_TL, 0);
    step(1, 0, A_TL, 0);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 9);
      logic [31:0] a, d;
      a = r < 8 ? BASE + 32'(4 * r) + 32'($urandom_range(0, 3)) :
          r == 8 ? $urandom : BASE ^ (32'h1 << $urandom_range(5, 31));
      d = $urandom_range(0, 1) ? $urandom : 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), a, d);
    end
    // asynchronous reset mid-count
    step(0, 1, A_TH, 32'h5);
    step(0, 1, A_TCON, 32'h3);
    step(0, 0, 0, 0);
    #2 reset = 0;
    m_reset();
    #1;
    chk_outs();
    chk("rd_async", read_data, 32'h0);
    #3 reset = 1;
    step(1, 0, A_TL, 0);
    chk("systick_restart", systick, 32'd1);
    step(1, 0, A_TL, 0);
    chk("tl_held", last_rd, 32'h0);
    step(1, 0, A_TCON, 0);
    chk("tcon_cleared", last_rd, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
